// File: rtl/tsmp_pkg.sv
// Shared constants and types for the TSMP frame parser and its output slot.
package tsmp_pkg;

    localparam logic [1:0] TSMP_TYPE_NONE   = 2'd0;
    localparam logic [1:0] TSMP_TYPE_READ   = 2'd1;
    localparam logic [1:0] TSMP_TYPE_WRITE  = 2'd2;
    localparam logic [1:0] TSMP_TYPE_CONFIG = 2'd3;

    localparam logic [7:0] TSMP_ETH_HI = 8'hFF;
    localparam logic [7:0] TSMP_ETH_LO = 8'h01;

    localparam logic [4:0] TSMP_OFS_ETH   = 5'd12;
    localparam logic [4:0] TSMP_OFS_TYPE  = 5'd14;
    localparam logic [4:0] TSMP_OFS_ADDR  = 5'd16;
    localparam logic [4:0] TSMP_OFS_WDATA = 5'd20;

    localparam logic [5:0] TSMP_MIN_LEN_READ  = 6'd20;
    localparam logic [5:0] TSMP_MIN_LEN_WRITE = 6'd24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_SKIP = 2'd2
    } tsmp_state_e;

endpackage

// File: rtl/tsmp_cmd_slot.sv
// Single-entry valid/ready command register; a load may coincide with an accept.
module tsmp_cmd_slot
    import tsmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [1:0]  load_type,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [1:0]  cmd_type,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_wdata,
    output logic        busy
);

    assign busy = cmd_valid & ~cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_type  <= TSMP_TYPE_NONE;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (load) begin
            cmd_valid <= 1'b1;
            cmd_type  <= load_type;
            cmd_addr  <= load_addr;
            cmd_wdata <= load_wdata;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tsmp_parser.sv
// TSMP frame decoder: filtered byte stream in, one register-access command per frame out.
// Define TSMP_PARSER_CNT_EN to build the saturating error/drop counters.
module tsmp_parser
    import tsmp_pkg::*;
#(
    parameter int DATA_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [1:0]            ov_cmd_type,
    output logic [31:0]           ov_cmd_addr,
    output logic [31:0]           ov_cmd_wdata,
    output logic [15:0]           ov_err_cnt,
    output logic [15:0]           ov_drop_cnt
);

    tsmp_state_e state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  type_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        flag;
    logic [7:0]  byte_val;
    logic        field_bad;
    logic [1:0]  type_new;
    logic [31:0] addr_new;
    logic [31:0] wdata_new;
    logic [5:0]  len;
    logic [5:0]  min_len;
    logic        frame_ok;
    logic        end_ok;
    logic        load;
    logic        busy;

    assign flag     = iv_data[DATA_WIDTH-1];
    assign byte_val = iv_data[7:0];

    // Field values include the current byte so the end byte itself can complete a field.
    always_comb begin
        field_bad = 1'b0;
        type_new  = type_q;
        addr_new  = addr_q;
        wdata_new = wdata_q;
        if (cnt_q == TSMP_OFS_ETH && byte_val != TSMP_ETH_HI)
            field_bad = 1'b1;
        if (cnt_q == TSMP_OFS_ETH + 5'd1 && byte_val != TSMP_ETH_LO)
            field_bad = 1'b1;
        if (cnt_q == TSMP_OFS_TYPE) begin
            if (byte_val >= 8'd1 && byte_val <= 8'd3)
                type_new = byte_val[1:0];
            else
                field_bad = 1'b1;
        end
        if (cnt_q >= TSMP_OFS_ADDR && cnt_q < TSMP_OFS_WDATA)
            addr_new = {addr_q[23:0], byte_val};
        if (cnt_q >= TSMP_OFS_WDATA && cnt_q <= TSMP_OFS_WDATA + 5'd3)
            wdata_new = {wdata_q[23:0], byte_val};
    end

    assign len      = {1'b0, cnt_q} + 6'd1;
    assign min_len  = (type_new == TSMP_TYPE_READ) ? TSMP_MIN_LEN_READ : TSMP_MIN_LEN_WRITE;
    assign frame_ok = !field_bad && (type_new != TSMP_TYPE_NONE) && (len >= min_len);
    assign end_ok   = (state_q == ST_RECV) && i_data_wr && flag && frame_ok;
    assign load     = end_ok && !busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            type_q  <= TSMP_TYPE_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (i_data_wr) begin
            case (state_q)
                ST_IDLE: begin
                    if (flag) begin
                        state_q <= ST_RECV;
                        cnt_q   <= 5'd1;
                        type_q  <= TSMP_TYPE_NONE;
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end
                end
                ST_RECV: begin
                    cnt_q <= (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                    if (flag)
                        state_q <= ST_IDLE;
                    else if (field_bad)
                        state_q <= ST_SKIP;
                    if (!field_bad) begin
                        type_q  <= type_new;
                        addr_q  <= addr_new;
                        wdata_q <= wdata_new;
                    end
                end
                ST_SKIP: begin
                    if (flag)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    tsmp_cmd_slot u_slot (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (load),
        .load_type  (type_new),
        .load_addr  (addr_new),
        .load_wdata ((type_new == TSMP_TYPE_READ) ? 32'd0 : wdata_new),
        .cmd_ready  (i_cmd_ready),
        .cmd_valid  (o_cmd_valid),
        .cmd_type   (ov_cmd_type),
        .cmd_addr   (ov_cmd_addr),
        .cmd_wdata  (ov_cmd_wdata),
        .busy       (busy)
    );

`ifdef TSMP_PARSER_CNT_EN
    logic err_evt;
    logic drop_evt;

    // One error per frame: a bad field diverts to SKIP, so the end byte is not counted again.
    always_comb begin
        err_evt  = 1'b0;
        drop_evt = end_ok && busy;
        if (state_q == ST_RECV && i_data_wr)
            err_evt = field_bad || (flag && !frame_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_err_cnt  <= '0;
            ov_drop_cnt <= '0;
        end else begin
            if (err_evt && ov_err_cnt != 16'hFFFF)
                ov_err_cnt <= ov_err_cnt + 16'd1;
            if (drop_evt && ov_drop_cnt != 16'hFFFF)
                ov_drop_cnt <= ov_drop_cnt + 16'd1;
        end
    end
`else
    assign ov_err_cnt  = '0;
    assign ov_drop_cnt = '0;
`endif

endmodule

// File: doc/tsmp_parser.md
# tsmp_parser

Downstream of the TSMP frame filter: consumes the 9-bit filtered byte stream (bit 8 flags the first and last byte of a frame) and decodes each TSMP frame into one register-access command. Captures type, address and write data, then presents the command on a valid/ready interface to the register/config bank. Malformed frames are dropped; a frame whose command cannot be accepted in time is also dropped, because the upstream stream has no backpressure.

## Interface
- DATA_WIDTH, 9: stream width; bit DATA_WIDTH-1 is the frame delimiter flag, bits 7:0 are the byte.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset; one clock; all state sampled on rising i_clk.
- iv_data  in  DATA_WIDTH  stream byte; flag bit set on the first and last byte of a frame.
- i_data_wr  in  1  iv_data valid this cycle; gaps allowed anywhere inside a frame.
- o_cmd_valid  out  1  command held on ov_cmd_*.
- i_cmd_ready  in  1  consumer accepts the command when high together with o_cmd_valid.
- ov_cmd_type  out  2  1 = read, 2 = write, 3 = config.
- ov_cmd_addr  out  32  address, big-endian from bytes 16-19.
- ov_cmd_wdata  out  32  write data, big-endian from bytes 20-23; 0 for reads.
- ov_err_cnt  out  16  malformed-frame count (see Configuration).
- ov_drop_cnt  out  16  valid frames lost because the output slot was busy (see Configuration).

## Operation
- Frame layout (byte index from 0): 0-11 MACs (ignored), 12-13 ethertype, which must be 0xFF 0x01, 14 type, 15 reserved (ignored), 16-19 addr, 20-23 wdata, then optional padding up to the end flag.
- Minimum length: read 20 bytes, write/config 24 bytes. Bytes beyond that are ignored.
- Byte counter: 5 bits, increments per accepted byte (i_data_wr high), saturates at 31.
- States:
  - IDLE: a byte with the flag set goes to RECV with count = 1. Bytes without the flag are ignored.
  - RECV: captures fields by index. A wrong ethertype byte or type not in 1..3 goes to SKIP and counts an error. A flagged byte is the end of frame and goes to IDLE.
  - SKIP: discards bytes until a flagged byte, then goes to IDLE.
- End of frame in RECV with count < minimum for the type: error, no command.
- End of frame in RECV with a valid frame loads the output slot if the slot is free. Otherwise the frame is dropped and ov_drop_cnt increments.
- Slot free means o_cmd_valid low, or o_cmd_valid and i_cmd_ready both high in the same cycle (accept and load coincide).
- Output slot: ov_cmd_* are stable while o_cmd_valid is high. o_cmd_valid clears on accept unless a new load occurs in the same cycle.
- A new frame may start on the byte immediately after an end byte; it is decoded normally while a command is still pending.
- Reset values: o_cmd_valid 0, ov_cmd_type 0, ov_cmd_addr 0, ov_cmd_wdata 0, counters 0, state IDLE.
- Reset mid-frame: the block returns to IDLE and any pending command is lost. The stale tail byte may start a bogus frame; it can raise ov_err_cnt but never produces a command.

## Timing
- Command latency: end byte accepted at cycle T gives o_cmd_valid high at T+1.
- Counter updates land at T+1 relative to the cycle in which the error or drop is detected.
- No combinational path from iv_data or i_data_wr to any output.
- i_cmd_ready may be held high permanently; back-to-back minimum-length frames must then produce one command each, with no loss.

## Configuration
- TSMP_PARSER_CNT_EN defined: ov_err_cnt and ov_drop_cnt are 16-bit saturating counters (hold at 0xFFFF), cleared by reset.
- TSMP_PARSER_CNT_EN undefined: the counter registers are absent and both outputs are tied to 0. Decode and drop behaviour are unchanged.

## Structure
- Shared package tsmp_pkg holds:
  - type constants TSMP_TYPE_NONE/READ/WRITE/CONFIG (0..3);
  - ethertype bytes 0xFF and 0x01;
  - field byte offsets 12, 14, 16, 20;
  - minimum lengths 20 and 24;
  - the state enum.
- One sub-module, tsmp_cmd_slot: the single-entry valid/ready output register, with inputs load, type, addr and wdata, and an output busy indication. The parser FSM and field capture stay in tsmp_parser.

## Test plan
- Write frame, 24 bytes, type 0x02, addr 0x00001234, wdata 0xDEADBEEF, i_cmd_ready = 1 -> one cycle after the end byte: o_cmd_valid = 1, type 2, addr 0x00001234, wdata 0xDEADBEEF.
- Read frame, 20 bytes plus 10 padding bytes, with i_data_wr gaps -> one command, type 1, wdata 0.
- Ethertype 0xFF02, then type 0x05, then a write frame truncated to 22 bytes -> no commands, ov_err_cnt = 3.
- i_cmd_ready = 0, two valid frames -> first command held stable, second dropped, ov_drop_cnt = 1. Raising ready in the end-byte cycle of a third frame -> accept and reload in the same cycle, with no drop.
- Back-to-back write frames with no idle cycles and ready always high -> N frames yield N commands.
- i_rst asserted at byte 10 of a frame -> all outputs 0 next cycle; the following clean frame decodes correctly. Repeat with the counter macro undefined -> counters read 0.
